// File: rtl/reorder_buffer.sv
// reorder_buffer: in-order retirement buffer with completion tracking and mispredict squash.
// Optional feature macro ROB_WB_BYPASS_EN: a writeback to the head entry retires it in the same cycle.
module reorder_buffer #(
  parameter int DEPTH         = 16,
  parameter int PHYS_REG_BITS = 6
) (
  input  logic                       clk,
  input  logic                       rst_i,
  input  logic                       alloc_valid_i,
  input  logic                       alloc_has_rd_i,
  input  logic [PHYS_REG_BITS-1:0]   alloc_pd_i,
  output logic                       alloc_ready_o,
  output logic [$clog2(DEPTH)-1:0]   alloc_tag_o,
  input  logic                       wb_valid_i,
  input  logic [$clog2(DEPTH)-1:0]   wb_tag_i,
  input  logic                       br_valid_i,
  input  logic                       br_hit_i,
  input  logic [$clog2(DEPTH)-1:0]   br_tag_i,
  output logic                       retire_o,
  output logic                       commit_valid_o,
  output logic [PHYS_REG_BITS-1:0]   commit_idx_o,
  output logic                       empty_o,
  output logic                       full_o
);

  localparam int TAG_BITS = $clog2(DEPTH);
  localparam int PTR_BITS = TAG_BITS + 1;

  logic [PTR_BITS-1:0]      head_q, head_d;
  logic [PTR_BITS-1:0]      tail_q, tail_d;
  logic [TAG_BITS-1:0]      head_idx;
  logic [TAG_BITS-1:0]      tail_idx;
  logic [TAG_BITS-1:0]      br_dist;

  logic [DEPTH-1:0]         valid_vec;
  logic [DEPTH-1:0]         done_vec;
  logic [DEPTH-1:0]         has_rd_vec;
  logic [PHYS_REG_BITS-1:0] pd_vec [DEPTH];

  logic                     mispredict_req;
  logic                     mispredict;
  logic                     wb_hit;
  logic                     alloc_fire;
  logic                     head_wb;
  logic                     head_done;

  assign head_idx = head_q[TAG_BITS-1:0];
  assign tail_idx = tail_q[TAG_BITS-1:0];

  assign empty_o = (head_q == tail_q);
  assign full_o  = (head_idx == tail_idx) && (head_q[TAG_BITS] != tail_q[TAG_BITS]);

  // Any mispredict request blocks allocation, even one that names an invalid tag.
  assign mispredict_req = br_valid_i & ~br_hit_i;
  assign mispredict     = mispredict_req & valid_vec[br_tag_i];
  assign br_dist        = br_tag_i - head_idx;

  assign wb_hit        = wb_valid_i & valid_vec[wb_tag_i];
  assign alloc_ready_o = ~full_o & ~mispredict_req;
  assign alloc_fire    = alloc_valid_i & alloc_ready_o;
  assign alloc_tag_o   = tail_idx;

  // The head is never younger than a resolving branch, so it cannot be squashed here.
  assign head_wb = wb_hit & (wb_tag_i == head_idx);

`ifdef ROB_WB_BYPASS_EN
  assign head_done = done_vec[head_idx] | head_wb;
`else
  assign head_done = done_vec[head_idx];
`endif

  assign retire_o       = valid_vec[head_idx] & head_done;
  assign commit_valid_o = retire_o & has_rd_vec[head_idx] & (pd_vec[head_idx] != '0);
  assign commit_idx_o   = commit_valid_o ? pd_vec[head_idx] : '0;

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    if (retire_o) begin
      head_d = head_q + PTR_BITS'(1);
    end
    // Rebuilding tail from head keeps the wrap bit consistent with the live distance.
    if (mispredict) begin
      tail_d = head_q + {1'b0, br_dist} + PTR_BITS'(1);
    end else if (alloc_fire) begin
      tail_d = tail_q + PTR_BITS'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst_i) begin
      head_q <= '0;
      tail_q <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    logic [TAG_BITS-1:0]      offset;
    logic                     squash;
    logic                     wb_here;
    logic                     retire_here;
    logic                     alloc_here;
    logic                     valid_q, valid_d;
    logic                     done_q, done_d;
    logic                     has_rd_q, has_rd_d;
    logic [PHYS_REG_BITS-1:0] pd_q, pd_d;

    // Age relative to head; anything strictly older-than-branch distance survives.
    assign offset      = TAG_BITS'(gi) - head_idx;
    assign squash      = mispredict & (offset > br_dist);
    assign wb_here     = wb_hit & (wb_tag_i == TAG_BITS'(gi)) & ~squash;
    assign retire_here = retire_o & (head_idx == TAG_BITS'(gi));
    assign alloc_here  = alloc_fire & (tail_idx == TAG_BITS'(gi));

    always_comb begin
      valid_d  = valid_q;
      done_d   = done_q;
      has_rd_d = has_rd_q;
      pd_d     = pd_q;
      if (wb_here) begin
        done_d = 1'b1;
      end
      if (squash || retire_here) begin
        valid_d = 1'b0;
        done_d  = 1'b0;
      end
      if (alloc_here) begin
        valid_d  = 1'b1;
        done_d   = 1'b0;
        has_rd_d = alloc_has_rd_i;
        pd_d     = alloc_pd_i;
      end
    end

    always_ff @(posedge clk) begin
      if (rst_i) begin
        valid_q  <= 1'b0;
        done_q   <= 1'b0;
        has_rd_q <= 1'b0;
        pd_q     <= '0;
      end else begin
        valid_q  <= valid_d;
        done_q   <= done_d;
        has_rd_q <= has_rd_d;
        pd_q     <= pd_d;
      end
    end

    assign valid_vec[gi]  = valid_q;
    assign done_vec[gi]   = done_q;
    assign has_rd_vec[gi] = has_rd_q;
    assign pd_vec[gi]     = pd_q;
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// tb_reorder_buffer: directed checks of allocation, in-order retire, full/wrap, reset and mispredict squash.
// Expectations follow the ROB_WB_BYPASS_EN setting used for the build.
module tb_reorder_buffer;

  localparam int DEPTH = 16;
  localparam int PRB   = 6;
  localparam int TB    = 4;
`ifdef ROB_WB_BYPASS_EN
  localparam int BYP = 1;
`else
  localparam int BYP = 0;
`endif

  logic           clk = 1'b0;
  logic           rst_i;
  logic           alloc_valid_i;
  logic           alloc_has_rd_i;
  logic [PRB-1:0] alloc_pd_i;
  logic           alloc_ready_o;
  logic [TB-1:0]  alloc_tag_o;
  logic           wb_valid_i;
  logic [TB-1:0]  wb_tag_i;
  logic           br_valid_i;
  logic           br_hit_i;
  logic [TB-1:0]  br_tag_i;
  logic           retire_o;
  logic           commit_valid_o;
  logic [PRB-1:0] commit_idx_o;
  logic           empty_o;
  logic           full_o;

  int checks = 0;
  int errors = 0;
  int pulses;
  int lo;
  int k;
  logic exp_r;
  logic exp_cv;
  logic [31:0] exp_idx;
  logic [31:0] drain_pd [4];

  always #5 clk = ~clk;

  reorder_buffer #(.DEPTH(DEPTH), .PHYS_REG_BITS(PRB)) dut (
    .clk           (clk),
    .rst_i         (rst_i),
    .alloc_valid_i (alloc_valid_i),
    .alloc_has_rd_i(alloc_has_rd_i),
    .alloc_pd_i    (alloc_pd_i),
    .alloc_ready_o (alloc_ready_o),
    .alloc_tag_o   (alloc_tag_o),
    .wb_valid_i    (wb_valid_i),
    .wb_tag_i      (wb_tag_i),
    .br_valid_i    (br_valid_i),
    .br_hit_i      (br_hit_i),
    .br_tag_i      (br_tag_i),
    .retire_o      (retire_o),
    .commit_valid_o(commit_valid_o),
    .commit_idx_o  (commit_idx_o),
    .empty_o       (empty_o),
    .full_o        (full_o)
  );

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
    $display("check %-14s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  initial begin
    rst_i = 1'b1; alloc_valid_i = 1'b0; alloc_has_rd_i = 1'b0; alloc_pd_i = '0;
    wb_valid_i = 1'b0; wb_tag_i = '0; br_valid_i = 1'b0; br_hit_i = 1'b0; br_tag_i = '0;
    step(); step();

    // Reset then idle
    rst_i = 1'b0; #1;
    chk("rst_empty", empty_o, 1);
    chk("rst_ready", alloc_ready_o, 1);
    chk("rst_tag", alloc_tag_o, 0);
    chk("rst_retire", retire_o, 0);
    chk("rst_cvalid", commit_valid_o, 0);
    chk("rst_cidx", commit_idx_o, 0);
    chk("rst_full", full_o, 0);
    step();

    // Out-of-order completion, in-order retire of pd 33,34,35
    for (int i = 0; i < 3; i++) begin
      alloc_valid_i = 1'b1; alloc_has_rd_i = 1'b1; alloc_pd_i = PRB'(33 + i); #1;
      chk("ord_tag", alloc_tag_o, i);
      step();
    end
    alloc_valid_i = 1'b0;
    lo = 3 - BYP;
    for (int c = 0; c < 7; c++) begin
      wb_valid_i = (c < 3); wb_tag_i = (c < 3) ? TB'(2 - c) : '0; #1;
      exp_r = (c >= lo) && (c < lo + 3);
      exp_idx = exp_r ? 32'(33 + c - lo) : 32'd0;
      chk("ord_retire", retire_o, exp_r);
      chk("ord_cidx", commit_idx_o, exp_idx);
      step();
    end
    wb_valid_i = 1'b0; #1;
    chk("ord_empty", empty_o, 1);

    // No-rd, pd=0 and pd=40: only pd=40 commits
    alloc_valid_i = 1'b1; alloc_has_rd_i = 1'b0; alloc_pd_i = 6'd7; #1;
    chk("nrd_tag", alloc_tag_o, 3);
    step();
    alloc_has_rd_i = 1'b1; alloc_pd_i = 6'd0; #1;
    chk("nrd_tag", alloc_tag_o, 4);
    step();
    alloc_pd_i = 6'd40; #1;
    chk("nrd_tag", alloc_tag_o, 5);
    step();
    alloc_valid_i = 1'b0;
    pulses = 0;
    lo = 1 - BYP;
    for (int c = 0; c < 5; c++) begin
      wb_valid_i = (c < 3); wb_tag_i = (c < 3) ? TB'(3 + c) : '0; #1;
      exp_r  = (c >= lo) && (c < lo + 3);
      exp_cv = (c == lo + 2);
      chk("nrd_retire", retire_o, exp_r);
      chk("nrd_cvalid", commit_valid_o, exp_cv);
      chk("nrd_cidx", commit_idx_o, exp_cv ? 32'd40 : 32'd0);
      pulses += int'(retire_o);
      step();
    end
    wb_valid_i = 1'b0;
    chk("nrd_pulses", pulses, 3);

    // Reset with live entries discards them
    alloc_valid_i = 1'b1; alloc_pd_i = 6'd20; step();
    alloc_pd_i = 6'd21; step();
    alloc_valid_i = 1'b0; wb_valid_i = 1'b1; wb_tag_i = 4'd7; step();
    wb_valid_i = 1'b0; rst_i = 1'b1; step();
    rst_i = 1'b0; #1;
    chk("mrst_empty", empty_o, 1);
    chk("mrst_retire", retire_o, 0);
    chk("mrst_tag", alloc_tag_o, 0);

    // Fill to full, retire head, wrap
    for (int i = 0; i < DEPTH; i++) begin
      alloc_valid_i = 1'b1; alloc_pd_i = PRB'(i + 1); #1;
      chk("fill_tag", alloc_tag_o, i);
      step();
    end
    wb_valid_i = 1'b1; wb_tag_i = 4'd0; #1;
    chk("full_flag", full_o, 1);
    chk("full_ready", alloc_ready_o, 0);
    chk("full_retire", retire_o, BYP);
    step();
    wb_valid_i = 1'b0; alloc_valid_i = 1'b0; #1;
    chk("full_flag1", full_o, 1 - BYP);
    chk("full_ready1", alloc_ready_o, BYP);
    chk("full_retire1", retire_o, 1 - BYP);
    step();
    alloc_valid_i = 1'b1; alloc_pd_i = 6'd50; #1;
    chk("wrap_full", full_o, 0);
    chk("wrap_ready", alloc_ready_o, 1);
    chk("wrap_tag", alloc_tag_o, 0);
    step();
    alloc_valid_i = 1'b0; #1;
    chk("refull", full_o, 1);
    rst_i = 1'b1; step();
    rst_i = 1'b0;

    // Mispredict at tag 2 with younger entries 3..5
    for (int i = 0; i < 6; i++) begin
      alloc_valid_i = 1'b1; alloc_pd_i = PRB'(10 + i); step();
    end
    br_valid_i = 1'b1; br_hit_i = 1'b0; br_tag_i = 4'd2;
    wb_valid_i = 1'b1; wb_tag_i = 4'd4; alloc_pd_i = 6'd63; #1;
    chk("mp_ready", alloc_ready_o, 0);
    step();
    br_valid_i = 1'b0; wb_valid_i = 1'b0; alloc_pd_i = 6'd60; #1;
    chk("mp_tag", alloc_tag_o, 3);
    chk("mp_ready1", alloc_ready_o, 1);
    step();
    alloc_valid_i = 1'b0;
    br_valid_i = 1'b1; br_hit_i = 1'b1; br_tag_i = 4'd1; #1;
    chk("hit_ready", alloc_ready_o, 1);
    chk("hit_tag", alloc_tag_o, 4);
    step();
    br_hit_i = 1'b0; br_tag_i = 4'd9; #1;
    chk("mpinv_ready", alloc_ready_o, 0);
    step();
    br_valid_i = 1'b0; #1;
    chk("mpinv_tag", alloc_tag_o, 4);

    drain_pd[0] = 10; drain_pd[1] = 11; drain_pd[2] = 12; drain_pd[3] = 60;
    pulses = 0;
    lo = 1 - BYP;
    for (int c = 0; c < 6; c++) begin
      wb_valid_i = (c < 4); wb_tag_i = (c < 4) ? TB'(c) : '0; #1;
      exp_r = (c >= lo) && (c < lo + 4);
      k = exp_r ? (c - lo) : 0;
      chk("mp_retire", retire_o, exp_r);
      chk("mp_cidx", commit_idx_o, exp_r ? drain_pd[k] : 32'd0);
      pulses += int'(retire_o);
      step();
    end
    wb_valid_i = 1'b0; #1;
    chk("mp_pulses", pulses, 4);
    chk("mp_empty", empty_o, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
